decode_mc_ext: RTL and testbench

- Next-generation multi-cycle ARM-subset control decoder. Contains the main control FSM, the ALU decoder, PC logic and the instruction decoder.
- Extends the previous decoder with a wider, parametrised ALU control field, four extra data-processing commands (EOR, MOV, CMP, TST), no-writeback handling, and an undefined-opcode trap.
- Adds a memory-ready handshake that stalls the fetch and memory states.
- Sits between the instruction register and the condlogic/datapath blocks.

---
 rtl/decode_mc_ext.sv | 218 +++++++++++++++++++++
 tb/tb_decode_mc_ext.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/decode_mc_ext.sv
// Multi-cycle ARM-subset control decoder: main FSM, ALU decoder, PC-write logic and instruction decoder.
// Outputs are combinational from the registered state; MemReady stalls FETCH, MEMRD and MEMWR.
module decode_mc_ext #(
  parameter int ALUCTRL_W = 3,
  parameter bit EXT_OPS   = 1'b1,
  parameter int STATE_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic                 MemReady,
  output logic                 PCS,
  output logic                 NextPC,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           FlagW,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 Undef,
  output logic [STATE_W-1:0]   state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_UNDEF  = 4'd10
  } state_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  state_e state_q, state_d;

  logic [3:0] cmd;
  logic       s_bit;
  logic       alu_op;
  logic       branch;
  logic       no_write;
  logic       is_cmp_tst;
  logic       arith_flags;
  logic [2:0] alu_ctl;
  logic       flag_nz;

  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];

  // Command decode is independent of ALUOp so EXECR/EXECI can steer on NoWrite.
  always_comb begin
    alu_ctl     = 3'b000;
    no_write    = 1'b0;
    is_cmp_tst  = 1'b0;
    arith_flags = 1'b0;
    unique case (cmd)
      CMD_ADD: begin
        alu_ctl     = 3'b000;
        arith_flags = 1'b1;
      end
      CMD_SUB: begin
        alu_ctl     = 3'b001;
        arith_flags = 1'b1;
      end
      CMD_AND: alu_ctl = 3'b010;
      CMD_ORR: alu_ctl = 3'b011;
      CMD_EOR: begin
        if (EXT_OPS) alu_ctl = 3'b100;
        else         no_write = 1'b1;
      end
      CMD_MOV: begin
        if (EXT_OPS) alu_ctl = 3'b101;
        else         no_write = 1'b1;
      end
      CMD_CMP: begin
        no_write = 1'b1;
        if (EXT_OPS) begin
          alu_ctl     = 3'b001;
          is_cmp_tst  = 1'b1;
          arith_flags = 1'b1;
        end
      end
      CMD_TST: begin
        no_write = 1'b1;
        if (EXT_OPS) begin
          alu_ctl    = 3'b010;
          is_cmp_tst = 1'b1;
        end
      end
      default: no_write = 1'b1;
    endcase
  end

  // Unsupported commands are flagged as no_write without is_cmp_tst; they never write flags.
  logic supported;
  assign supported = ~no_write | is_cmp_tst;
  assign flag_nz   = supported & (s_bit | is_cmp_tst);

  always_comb begin
    ALUControl = '0;
    FlagW      = 2'b00;
    if (alu_op) begin
      ALUControl[2:0] = alu_ctl;
      FlagW[1]        = flag_nz;
      FlagW[0]        = flag_nz & arith_flags;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        unique case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNDEF;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:  state_d = no_write ? S_FETCH : S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BRANCH,
      S_UNDEF:  state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    alu_op    = 1'b0;
    branch    = 1'b0;
    Undef     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        IRWrite   = MemReady;
        NextPC    = MemReady;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECR: alu_op = 1'b1;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      S_ALUWB: RegW = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      S_UNDEF: Undef = 1'b1;
      default: ;
    endcase
  end

  assign PCS    = ((Rd == 4'hF) & RegW) | branch;
  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

  always_comb begin
    state      = '0;
    state[3:0] = state_q;
  end

endmodule

// File: tb/tb_decode_mc_ext.sv
// Directed bench for decode_mc_ext: per-cycle expectations queued at drive time, checked mid-cycle.
module tb_decode_mc_ext;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       MemReady;

  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA, Undef;
  logic [1:0] ResultSrc, ALUSrcB, FlagW, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  logic       PCS0, NextPC0, RegW0, MemW0, IRWrite0, AdrSrc0, ALUSrcA0, Undef0;
  logic [1:0] ResultSrc0, ALUSrcB0, FlagW0, ImmSrc0, RegSrc0;
  logic [3:0] ALUControl0;
  logic [3:0] state0;

  int checks = 0;
  int errors = 0;

  decode_mc_ext #(.ALUCTRL_W(3), .EXT_OPS(1'b1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .FlagW(FlagW), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .Undef(Undef), .state(state)
  );

  decode_mc_ext #(.ALUCTRL_W(4), .EXT_OPS(1'b0), .STATE_W(4)) dut0 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
    .PCS(PCS0), .NextPC(NextPC0), .RegW(RegW0), .MemW(MemW0), .IRWrite(IRWrite0),
    .AdrSrc(AdrSrc0), .ResultSrc(ResultSrc0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0),
    .FlagW(FlagW0), .ALUControl(ALUControl0), .ImmSrc(ImmSrc0), .RegSrc(RegSrc0),
    .Undef(Undef0), .state(state0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe groups: {PCS, NextPC, RegW, MemW, IRWrite, Undef}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_IRNP = 6'b010010;
  localparam logic [5:0] S_RW   = 6'b001000;
  localparam logic [5:0] S_MW   = 6'b000100;
  localparam logic [5:0] S_PCRW = 6'b101000;
  localparam logic [5:0] S_PC   = 6'b100000;
  localparam logic [5:0] S_UND  = 6'b000001;
  // Select groups: {AdrSrc, ResultSrc[1:0], ALUSrcA, ALUSrcB[1:0]}
  localparam logic [5:0] L_FD   = 6'b010110;
  localparam logic [5:0] L_0    = 6'b000000;
  localparam logic [5:0] L_IMM  = 6'b000001;
  localparam logic [5:0] L_ADR  = 6'b100000;
  localparam logic [5:0] L_WB   = 6'b001000;
  localparam logic [5:0] L_BR   = 6'b010001;

  typedef struct {
    string       tag;
    logic [20:0] v;
  } exp_t;

  exp_t sb[$];

  function automatic logic [20:0] observe();
    return {state, PCS, NextPC, RegW, MemW, IRWrite, Undef,
            AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, FlagW};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs after the edge, queue the expected outputs, compare at the falling edge.
  task automatic step(input string tag, input logic rst, input logic [1:0] op,
                      input logic [5:0] fn, input logic [3:0] rd, input logic mr,
                      input logic [3:0] st, input logic [5:0] strb, input logic [5:0] sel,
                      input logic [2:0] alu, input logic [1:0] flg);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    Op       = op;
    Funct    = fn;
    Rd       = rd;
    MemReady = mr;
    e.tag = tag;
    e.v   = {st, strb, sel, alu, flg};
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(e.tag, {11'd0, observe()}, {11'd0, e.v});
    end
  endtask

  localparam logic [5:0] F_ADD  = 6'b001000;
  localparam logic [5:0] F_CMPI = 6'b110101;
  localparam logic [5:0] F_STR  = 6'b000000;
  localparam logic [5:0] F_LDR  = 6'b000001;
  localparam logic [5:0] F_EOR  = 6'b000011;

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = F_ADD; Rd = 4'd3; MemReady = 1'b0;

    step("reset",      1, 2'b00, F_ADD, 4'd3, 0, 4'd0, S_NONE, L_FD, 3'b000, 2'b00);
    step("fetch_w0",   0, 2'b00, F_ADD, 4'd3, 0, 4'd0, S_NONE, L_FD, 3'b000, 2'b00);
    step("fetch_w1",   0, 2'b00, F_ADD, 4'd3, 0, 4'd0, S_NONE, L_FD, 3'b000, 2'b00);
    step("fetch_w2",   0, 2'b00, F_ADD, 4'd3, 0, 4'd0, S_NONE, L_FD, 3'b000, 2'b00);
    step("fetch_rdy",  0, 2'b00, F_ADD, 4'd3, 1, 4'd0, S_IRNP, L_FD, 3'b000, 2'b00);
    step("add_dec",    0, 2'b00, F_ADD, 4'd3, 1, 4'd1, S_NONE, L_FD, 3'b000, 2'b00);
    step("add_execr",  0, 2'b00, F_ADD, 4'd3, 1, 4'd6, S_NONE, L_0,  3'b000, 2'b00);
    step("add_aluwb",  0, 2'b00, F_ADD, 4'd3, 1, 4'd8, S_RW,   L_0,  3'b000, 2'b00);

    step("cmp_fetch",  0, 2'b00, F_CMPI, 4'd0, 1, 4'd0, S_IRNP, L_FD,  3'b000, 2'b00);
    step("cmp_dec",    0, 2'b00, F_CMPI, 4'd0, 1, 4'd1, S_NONE, L_FD,  3'b000, 2'b00);
    step("cmp_execi",  0, 2'b00, F_CMPI, 4'd0, 1, 4'd7, S_NONE, L_IMM, 3'b001, 2'b11);

    step("str_fetch",  0, 2'b01, F_STR, 4'd2, 1, 4'd0, S_IRNP, L_FD,  3'b000, 2'b00);
    step("str_dec",    0, 2'b01, F_STR, 4'd2, 1, 4'd1, S_NONE, L_FD,  3'b000, 2'b00);
    step("str_adr",    0, 2'b01, F_STR, 4'd2, 1, 4'd2, S_NONE, L_IMM, 3'b000, 2'b00);
    step("str_wr_h0",  0, 2'b01, F_STR, 4'd2, 0, 4'd5, S_MW,   L_ADR, 3'b000, 2'b00);
    step("str_wr_h1",  0, 2'b01, F_STR, 4'd2, 0, 4'd5, S_MW,   L_ADR, 3'b000, 2'b00);
    step("str_wr_rdy", 0, 2'b01, F_STR, 4'd2, 1, 4'd5, S_MW,   L_ADR, 3'b000, 2'b00);

    step("ldr_fetch",  0, 2'b01, F_LDR, 4'hF, 1, 4'd0, S_IRNP, L_FD,  3'b000, 2'b00);
    step("ldr_dec",    0, 2'b01, F_LDR, 4'hF, 1, 4'd1, S_NONE, L_FD,  3'b000, 2'b00);
    step("ldr_adr",    0, 2'b01, F_LDR, 4'hF, 1, 4'd2, S_NONE, L_IMM, 3'b000, 2'b00);
    step("ldr_rd",     0, 2'b01, F_LDR, 4'hF, 1, 4'd3, S_NONE, L_ADR, 3'b000, 2'b00);
    step("ldr_wb_pc",  0, 2'b01, F_LDR, 4'hF, 1, 4'd4, S_PCRW, L_WB,  3'b000, 2'b00);

    step("und_fetch",  0, 2'b11, 6'd0, 4'd0, 1, 4'd0,  S_IRNP, L_FD, 3'b000, 2'b00);
    step("und_dec",    0, 2'b11, 6'd0, 4'd0, 1, 4'd1,  S_NONE, L_FD, 3'b000, 2'b00);
    step("und_pulse",  0, 2'b11, 6'd0, 4'd0, 1, 4'd10, S_UND,  L_0,  3'b000, 2'b00);

    step("b_fetch",    0, 2'b10, 6'd0, 4'd0, 1, 4'd0, S_IRNP, L_FD, 3'b000, 2'b00);
    step("b_dec",      0, 2'b10, 6'd0, 4'd0, 1, 4'd1, S_NONE, L_FD, 3'b000, 2'b00);
    step("b_branch",   0, 2'b10, 6'd0, 4'd0, 1, 4'd9, S_PC,   L_BR, 3'b000, 2'b00);
    chk("b_regsrc", {30'd0, RegSrc}, 32'h1);
    chk("b_immsrc", {30'd0, ImmSrc}, 32'h2);

    step("eor_fetch",  0, 2'b00, F_EOR, 4'd1, 1, 4'd0, S_IRNP, L_FD, 3'b000, 2'b00);
    step("eor_dec",    0, 2'b00, F_EOR, 4'd1, 1, 4'd1, S_NONE, L_FD, 3'b000, 2'b00);
    step("eor_execr",  0, 2'b00, F_EOR, 4'd1, 1, 4'd6, S_NONE, L_0,  3'b100, 2'b10);
    chk("eor0_aluctl", {28'd0, ALUControl0}, 32'h0);
    chk("eor0_flagw",  {30'd0, FlagW0},      32'h0);
    chk("eor0_state",  {28'd0, state0},      32'd6);
    step("eor_aluwb",  0, 2'b00, F_EOR, 4'd1, 1, 4'd8, S_RW,   L_0,  3'b000, 2'b00);
    chk("eor0_nowb_state", {28'd0, state0}, 32'd0);
    chk("eor0_nowb_regw",  {31'd0, RegW0},   32'd0);

    step("rst2",       1, 2'b01, F_LDR, 4'd4, 0, 4'd0, S_NONE, L_FD,  3'b000, 2'b00);
    step("ldr2_fetch", 0, 2'b01, F_LDR, 4'd4, 1, 4'd0, S_IRNP, L_FD,  3'b000, 2'b00);
    step("ldr2_dec",   0, 2'b01, F_LDR, 4'd4, 1, 4'd1, S_NONE, L_FD,  3'b000, 2'b00);
    step("ldr2_adr",   0, 2'b01, F_LDR, 4'd4, 1, 4'd2, S_NONE, L_IMM, 3'b000, 2'b00);
    step("ldr2_hold",  0, 2'b01, F_LDR, 4'd4, 0, 4'd3, S_NONE, L_ADR, 3'b000, 2'b00);
    step("ldr2_rst",   1, 2'b01, F_LDR, 4'd4, 0, 4'd3, S_NONE, L_ADR, 3'b000, 2'b00);
    step("post_rst",   0, 2'b01, F_LDR, 4'd4, 0, 4'd0, S_NONE, L_FD,  3'b000, 2'b00);
    chk("post_rst0_state", {28'd0, state0}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
